// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: memory opcodes, FSM states and
// access sizes.
package mem_stage_pkg;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: opcode decode, alignment check, big-endian lane
// select, store replication and load extract/extend.
module mem_lane_unit
  import mem_stage_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        is_store_o,
  output logic        misaligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  size_e       size;
  logic        sext;
  logic        bad_align;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    is_mem_o   = 1'b1;
    is_store_o = 1'b0;
    size       = SZ_WORD;
    sext       = 1'b0;
    case (op_i)
      OP_LB:  begin size = SZ_BYTE; sext = 1'b1; end
      OP_LH:  begin size = SZ_HALF; sext = 1'b1; end
      OP_LW:  size = SZ_WORD;
      OP_LBU: size = SZ_BYTE;
      OP_LHU: size = SZ_HALF;
      OP_SB:  begin size = SZ_BYTE; is_store_o = 1'b1; end
      OP_SH:  begin size = SZ_HALF; is_store_o = 1'b1; end
      OP_SW:  begin size = SZ_WORD; is_store_o = 1'b1; end
      default: is_mem_o = 1'b0;
    endcase
  end

  // Byte offset 0 sits in the most significant lane (big-endian).
  always_comb begin
    bad_align   = 1'b0;
    sel_o       = 4'b1111;
    wdata_o     = store_data_i;
    byte_v      = 8'h00;
    half_v      = 16'h0000;
    load_data_o = rdata_i;
    case (size)
      SZ_BYTE: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
        case (addr_lo_i)
          2'd0:    byte_v = rdata_i[31:24];
          2'd1:    byte_v = rdata_i[23:16];
          2'd2:    byte_v = rdata_i[15:8];
          default: byte_v = rdata_i[7:0];
        endcase
        load_data_o = {{24{sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        bad_align   = addr_lo_i[0];
        sel_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o     = {2{store_data_i[15:0]}};
        half_v      = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        load_data_o = {{16{sext & half_v[15]}}, half_v};
      end
      default: bad_align = |addr_lo_i;
    endcase
    misaligned_o = is_mem_o & bad_align;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through and runs load/store
// accesses over a req/ack bus with timeout, flush and misalignment handling.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  aluop_i,
  input  logic        wreg_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        out_valid_o,
  output logic        wreg_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          discard_q, discard_d;
  logic [7:0]    op_q, op_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic          pwreg_q, pwreg_d;
  logic [4:0]    pwaddr_q, pwaddr_d;
  logic          req_q, req_d, we_q, we_d;
  logic [31:0]   baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          ov_q, ov_d, err_q, err_d, wreg_q, wreg_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          in_bus, drop;
  logic          l_is_mem, l_is_store, l_misaligned;
  logic [3:0]    l_sel;
  logic [31:0]   l_wdata, l_load;

  // One lane unit serves both phases: decode the arriving op in IDLE and
  // extract the load result from the latched op in BUS.
  assign in_bus = (state_q == S_BUS);

  mem_lane_unit u_lane (
    .op_i         (in_bus ? op_q : aluop_i),
    .addr_lo_i    (in_bus ? addr_lo_q : mem_addr_i[1:0]),
    .store_data_i (store_data_i),
    .rdata_i      (bus_rdata_i),
    .is_mem_o     (l_is_mem),
    .is_store_o   (l_is_store),
    .misaligned_o (l_misaligned),
    .sel_o        (l_sel),
    .wdata_o      (l_wdata),
    .load_data_o  (l_load)
  );

  assign drop = discard_q | flush_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    op_d      = op_q;
    addr_lo_d = addr_lo_q;
    pwreg_d   = pwreg_q;
    pwaddr_d  = pwaddr_q;
    req_d     = req_q;
    we_d      = we_q;
    baddr_d   = baddr_q;
    sel_d     = sel_q;
    bwdata_d  = bwdata_q;
    ov_d      = 1'b0;
    err_d     = 1'b0;
    wreg_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !flush_i) begin
          if (!l_is_mem) begin
            ov_d    = 1'b1;
            wreg_d  = wreg_i;
            waddr_d = waddr_i;
            wdata_d = wdata_i;
          end else if (l_misaligned) begin
            ov_d    = 1'b1;
            err_d   = 1'b1;
            waddr_d = waddr_i;
          end else begin
            state_d   = S_BUS;
            cnt_d     = '0;
            discard_d = 1'b0;
            op_d      = aluop_i;
            addr_lo_d = mem_addr_i[1:0];
            pwreg_d   = wreg_i;
            pwaddr_d  = waddr_i;
            req_d     = 1'b1;
            we_d      = l_is_store;
            baddr_d   = {mem_addr_i[31:2], 2'b00};
            sel_d     = l_sel;
            bwdata_d  = l_wdata;
          end
        end
      end
      S_BUS: begin
        if (flush_i) discard_d = 1'b1;
        if (bus_ack_i) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          discard_d = 1'b0;
          ov_d      = !drop;
          wreg_d    = !drop && !l_is_store && pwreg_q;
          waddr_d   = pwaddr_q;
          wdata_d   = l_is_store ? ZeroWord : l_load;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          discard_d = 1'b0;
          ov_d      = !drop;
          err_d     = !drop;
          waddr_d   = pwaddr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      op_q      <= 8'h00;
      addr_lo_q <= 2'b00;
      pwreg_q   <= 1'b0;
      pwaddr_q  <= 5'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= ZeroWord;
      sel_q     <= 4'b0000;
      bwdata_q  <= ZeroWord;
      ov_q      <= 1'b0;
      err_q     <= 1'b0;
      wreg_q    <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= ZeroWord;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      op_q      <= op_d;
      addr_lo_q <= addr_lo_d;
      pwreg_q   <= pwreg_d;
      pwaddr_q  <= pwaddr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      baddr_q   <= baddr_d;
      sel_q     <= sel_d;
      bwdata_q  <= bwdata_d;
      ov_q      <= ov_d;
      err_q     <= err_d;
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = baddr_q;
  assign bus_sel_o   = sel_q;
  assign bus_wdata_o = bwdata_q;
  assign out_valid_o = ov_q;
  assign err_o       = err_q;
  assign wreg_o      = wreg_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-back results are queued at
// issue time and matched against every out_valid_o pulse.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] OP_OR = 8'h25;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [7:0]  aluop_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i, mem_addr_i, store_data_i;
  logic        flush_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic        out_valid_o, wreg_o, err_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  typedef struct {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .aluop_i(aluop_i), .wreg_i(wreg_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .out_valid_o(out_valid_o), .wreg_o(wreg_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Output monitor: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (err_o && !out_valid_o) begin
      checks++; failures++;
      $display("FAIL err_without_valid err=%0b out_valid=%0b", err_o, out_valid_o);
    end
    if (out_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got wreg=%0b waddr=%0d wdata=%h err=%0b",
                 wreg_o, waddr_o, wdata_o, err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wreg_o !== e.wreg || err_o !== e.err ||
            (e.wreg && (waddr_o !== e.waddr || wdata_o !== e.wdata))) begin
          failures++;
          $display("FAIL out_compare got wreg=%0b waddr=%0d wdata=%h err=%0b exp wreg=%0b waddr=%0d wdata=%h err=%0b",
                   wreg_o, waddr_o, wdata_o, err_o, e.wreg, e.waddr, e.wdata, e.err);
        end
      end
    end
  end

  function automatic exp_t mk(input logic w, input logic [4:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    x.wreg = w; x.waddr = a; x.wdata = d; x.err = e;
    return x;
  endfunction

  // Present one op for one edge; returns #1 after the accepting edge.
  task automatic issue(input logic [7:0] op, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] addr, input logic [31:0] sd);
    in_valid_i = 1'b1; aluop_i = op; wreg_i = w; waddr_i = a;
    wdata_i = d; mem_addr_i = addr; store_data_i = sd;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Ack after 'waits' wait cycles; reports how many cycles in_ready_o was low.
  task automatic respond(input int waits, input logic [31:0] rd, output int busy);
    busy = 0;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin bus_ack_i = 1'b1; bus_rdata_i = rd; end
      @(negedge clk);
      if (!in_ready_o) busy++;
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid_i = 0; aluop_i = 0; wreg_i = 0; waddr_i = 0; wdata_i = 0;
    mem_addr_i = 0; store_data_i = 0; flush_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    idle(3);
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1 || bus_req_o !== 1'b0 || out_valid_o !== 1'b0 || err_o !== 1'b0 ||
        bus_we_o !== 1'b0 || bus_addr_o !== 32'h0 || bus_sel_o !== 4'h0 || bus_wdata_o !== 32'h0 ||
        wreg_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_state ready=%0b req=%0b ov=%0b err=%0b sel=%h addr=%h wdata=%h",
               in_ready_o, bus_req_o, out_valid_o, err_o, bus_sel_o, bus_addr_o, wdata_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_nonmem;
    sb.push_back(mk(1'b1, 5'd5, 32'h0000_00FF, 1'b0));
    issue(OP_OR, 1'b1, 5'd5, 32'h0000_00FF, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL nonmem_no_req req=%0b ready=%0b exp 0/1", bus_req_o, in_ready_o);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(i != 1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0));
      issue(OP_OR, i != 1, 5'(10 + i), 32'hA000_0000 + 32'(i), 32'h0, 32'h0);
    end
    idle(2);
  endtask

  task automatic test_load_byte;
    int busy;
    sb.push_back(mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0));
    issue(OP_LB, 1'b1, 5'd7, 32'h0, 32'h0000_0103, 32'h0);
    checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_sel_o !== 4'b0001 || bus_addr_o !== 32'h0000_0100) begin
      failures++;
      $display("FAIL lb_bus req=%0b we=%0b sel=%b addr=%h exp 1/0/0001/00000100",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
    end
    respond(3, 32'h1122_3380, busy);
    checks++;
    if (busy !== 4) begin
      failures++;
      $display("FAIL lb_busy_cycles got=%0d exp=4", busy);
    end
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL lb_done req=%0b ready=%0b exp 0/1", bus_req_o, in_ready_o);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_load_half;
    int busy;
    sb.push_back(mk(1'b1, 5'd8, 32'h0000_8001, 1'b0));
    issue(OP_LHU, 1'b1, 5'd8, 32'h0, 32'h0000_0102, 32'h0);
    checks++;
    if (bus_sel_o !== 4'b0011 || bus_req_o !== 1'b1) begin
      failures++;
      $display("FAIL lhu_sel got=%b req=%0b exp 0011/1", bus_sel_o, bus_req_o);
    end
    respond(0, 32'hAAAA_8001, busy);
    checks++;
    if (busy !== 1) begin
      failures++;
      $display("FAIL lhu_busy_cycles got=%0d exp=1", busy);
    end
    sb.push_back(mk(1'b1, 5'd9, 32'hFFFF_8001, 1'b0));
    issue(OP_LH, 1'b1, 5'd9, 32'h0, 32'h0000_0200, 32'h0);
    respond(1, 32'h8001_1234, busy);
    sb.push_back(mk(1'b1, 5'd3, 32'h0000_0034, 1'b0));
    issue(OP_LBU, 1'b1, 5'd3, 32'h0, 32'h0000_0202, 32'h0);
    respond(0, 32'h8001_34FF, busy);
    sb.push_back(mk(1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0));
    issue(OP_LW, 1'b1, 5'd4, 32'h0, 32'h0000_0204, 32'h0);
    respond(2, 32'hDEAD_BEEF, busy);
    idle(1);
  endtask

  task automatic test_store;
    int busy;
    sb.push_back(mk(1'b0, 5'd6, 32'h0, 1'b0));
    issue(OP_SH, 1'b1, 5'd6, 32'h0, 32'h0000_0100, 32'h0000_BEEF);
    checks++;
    if (bus_we_o !== 1'b1 || bus_sel_o !== 4'b1100 || bus_wdata_o !== 32'hBEEF_BEEF || bus_addr_o !== 32'h100) begin
      failures++;
      $display("FAIL sh_bus we=%0b sel=%b wdata=%h addr=%h exp 1/1100/BEEFBEEF/00000100",
               bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o);
    end
    respond(1, 32'h0, busy);
    sb.push_back(mk(1'b0, 5'd6, 32'h0, 1'b0));
    issue(OP_SB, 1'b1, 5'd6, 32'h0, 32'h0000_0302, 32'h1234_56A5);
    checks++;
    if (bus_sel_o !== 4'b0010 || bus_wdata_o !== 32'hA5A5_A5A5 || bus_addr_o !== 32'h300) begin
      failures++;
      $display("FAIL sb_bus sel=%b wdata=%h addr=%h exp 0010/A5A5A5A5/00000300",
               bus_sel_o, bus_wdata_o, bus_addr_o);
    end
    respond(0, 32'h0, busy);
    idle(1);
  endtask

  task automatic test_misaligned;
    sb.push_back(mk(1'b0, 5'd2, 32'h0, 1'b1));
    issue(OP_LW, 1'b1, 5'd2, 32'h0, 32'h0000_0101, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL lw_misaligned_req req=%0b ready=%0b exp 0/1", bus_req_o, in_ready_o);
    end
    @(posedge clk); #1;
    sb.push_back(mk(1'b0, 5'd2, 32'h0, 1'b1));
    issue(OP_SH, 1'b0, 5'd2, 32'h0, 32'h0000_0103, 32'h0);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL sh_misaligned_req req=%0b exp 0", bus_req_o);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_timeout;
    int n;
    bit done;
    n = 0; done = 0;
    sb.push_back(mk(1'b0, 5'd1, 32'h0, 1'b1));
    issue(OP_LW, 1'b1, 5'd1, 32'h0, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 3 * TIMEOUT && !done; i++) begin
      @(negedge clk);
      if (bus_req_o) n++;
      else done = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== TIMEOUT || !done) begin
      failures++;
      $display("FAIL timeout_req_cycles got=%0d exp=%0d ended=%0b", n, TIMEOUT, done);
    end
    idle(1);
  endtask

  task automatic test_flush;
    int busy;
    issue(OP_LW, 1'b1, 5'd12, 32'h0, 32'h0000_0500, 32'h0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_req_held req=%0b exp 1", bus_req_o);
    end
    respond(2, 32'h5555_5555, busy);
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_done req=%0b ready=%0b exp 0/1", bus_req_o, in_ready_o);
    end
    @(posedge clk); #1;
    // Flush on the arriving op in IDLE: nothing at all happens.
    flush_i = 1'b1;
    issue(OP_LW, 1'b1, 5'd13, 32'h0, 32'h0000_0600, 32'h0);
    flush_i = 1'b0;
    checks++;
    if (bus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_req req=%0b exp 0", bus_req_o);
    end
    // Discard flag must not leak into the next access.
    sb.push_back(mk(1'b1, 5'd14, 32'h0BAD_F00D, 1'b0));
    issue(OP_LW, 1'b1, 5'd14, 32'h0, 32'h0000_0700, 32'h0);
    respond(0, 32'h0BAD_F00D, busy);
    idle(1);
  endtask

  task automatic test_reset_mid_bus;
    issue(OP_LW, 1'b1, 5'd15, 32'h0, 32'h0000_0800, 32'h0);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus_req_o !== 1'b0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_bus req=%0b ready=%0b ov=%0b exp 0/1/0", bus_req_o, in_ready_o, out_valid_o);
    end
    // Late ack from the abandoned request lands in IDLE and is ignored.
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    idle(2);
    sb.push_back(mk(1'b1, 5'd16, 32'h1357_9BDF, 1'b0));
    issue(OP_OR, 1'b1, 5'd16, 32'h1357_9BDF, 32'h0, 32'h0);
    idle(2);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drained pending=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_nonmem;
    test_back_to_back;
    test_load_byte;
    test_load_half;
    test_store;
    test_misaligned;
    test_timeout;
    test_flush;
    test_reset_mid_bus;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
